mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: LEN_W, default 10, width of transfer length and word counter.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a copy; sampled on rising clk.
REQ-005 Port: abort  input  1  synchronous cancel of an active copy.
REQ-006 Port: src_addr  input  32  word address of first source word.
REQ-007 Port: dst_addr  input  32  word address of first destination word.
REQ-008 Port: length  input  LEN_W  number of words to copy; 0 is legal.
REQ-009 Port: busy  output  1  high while in RD or WR state.
REQ-010 Port: done  output  1  one-cycle pulse on completion or abort.
REQ-011 Port: words_done  output  LEN_W  count of words written in current/last copy.
REQ-012 Port: mem_add  output  32  word address to data memory.
REQ-013 Port: mem_wdata  output  32  write data to data memory.
REQ-014 Port: mem_rdata  input  32  combinational read data from data memory.
REQ-015 Port: mem_read  output  1  read enable to data memory.
REQ-016 Port: mem_write  output  1  write enable to data memory; memory writes on the rising clk where it is high.

Function
REQ-017 States: IDLE, RD, WR, DONE; state, src/dst/len latches, buffer and counter are registers.
REQ-018 IDLE: start=1 latches src_addr, dst_addr, length, clears words_done; next state RD if length!=0, else DONE.
REQ-019 start while not IDLE is ignored; input ports other than start/abort are ignored outside the IDLE start cycle.
REQ-020 RD: mem_read=1, mem_write=0, mem_add=src+words_done; mem_rdata captured into buffer at end of cycle; next WR.
REQ-021 WR: mem_write=1, mem_read=0, mem_add=dst+words_done, mem_wdata=buffer; words_done increments at end of cycle; next DONE if words_done+1==len, else RD.
REQ-022 DONE: done=1 for exactly one cycle, memory strobes low; next IDLE.
REQ-023 IDLE/DONE: mem_read=0, mem_write=0, mem_add=0, mem_wdata=0.
REQ-024 mem_* outputs are decoded from registered state only (no combinational path from start/abort).
REQ-025 Throughput: 2 cycles per word; done high in cycle 2*length+1 after the start-sampling edge; length=0 gives done in cycle 1.
REQ-026 Address arithmetic is 32-bit modulo 2^32; src+words_done wraps from 0xFFFFFFFF to 0.
REQ-027 Copy order strictly ascending; overlapping regions with dst>src are not corrected (forward copy semantics).
REQ-028 abort=1 in RD: no write issued; next DONE. abort=1 in WR: the write presented that cycle completes and counts; next DONE.
REQ-029 abort in IDLE or DONE has no effect; abort and start in the same IDLE cycle: start wins.
REQ-030 words_done holds its final value in IDLE until the next accepted start.
REQ-031 length = 2^LEN_W-1 (max) completes without counter overflow.

Reset
REQ-032 reset=1 forces state IDLE, busy=0, done=0, words_done=0, buffer=0, all mem_* outputs 0, immediately and asynchronously.
REQ-033 reset mid-copy abandons the transfer without done pulse; a write in progress at the reset edge is not guaranteed.
REQ-034 First start is accepted on the first rising clk after reset deasserts.

Verification
REQ-035 Memory word 1=0x000000A5, 2=0x1, 3=0x2; start src=1,dst=32,len=3 -> mem[32..34]=0xA5,0x1,0x2; done in cycle 7; words_done=3.
REQ-036 start len=0 -> no mem_read/mem_write ever high; done in cycle 1; words_done=0.
REQ-037 start len=4, abort asserted in second WR cycle (cycle 4) -> exactly 2 words written; done in cycle 5; words_done=2.
REQ-038 src=0xFFFFFFFF, len=2 -> reads at 0xFFFFFFFF then 0x00000000; start pulsed while busy -> ignored, copy unchanged.
REQ-039 reset asserted in cycle 3 of a len=3 copy -> all outputs 0 at once; no done pulse; new start after release runs normally.
REQ-040 Back-to-back: start in the IDLE cycle right after done -> second copy accepted with correct words_done restart at 0.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Word-by-word memory copy engine. After a start request it reads
//   `length` words from src_addr upward and writes them to dst_addr upward.
//   Each word takes one RD cycle and then one WR cycle. At the end, or
//   after an abort, it pulses done for one cycle.
//
// Ports
//   clk, reset        : clock (rising edge) and asynchronous active-high reset
//   start, abort      : copy request (IDLE only) and synchronous cancel
//   src_addr, dst_addr: first source / destination word address
//   length            : number of words to copy (0 is legal)
//   busy, done        : in RD/WR state; one-cycle completion pulse
//   words_done        : words written in the current or last copy
//   mem_add, mem_wdata, mem_rdata, mem_read, mem_write : data memory port
module mem_copy_engine #(
    parameter int unsigned LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_add,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             mem_read,
    output logic             mem_write
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_inc;

    assign cnt_inc = words_done + ONE;

    // All outputs are registered. Each transition loads the values that
    // belong to the state being entered. mem_wdata doubles as the read
    // buffer: it captures mem_rdata at the end of RD and is driven out in WR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            words_done <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_add    <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= length;
                        words_done <= '0;
                        if (length != '0) begin
                            state    <= RD;
                            busy     <= 1'b1;
                            mem_read <= 1'b1;
                            mem_add  <= src_addr;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (abort) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_add   <= '0;
                        mem_wdata <= '0;
                    end else begin
                        state     <= WR;
                        mem_write <= 1'b1;
                        mem_add   <= dst_q + 32'(words_done);
                        mem_wdata <= mem_rdata;
                    end
                end
                WR: begin
                    // The write presented this cycle always completes and
                    // counts, even when abort is high.
                    words_done <= cnt_inc;
                    mem_write  <= 1'b0;
                    mem_wdata  <= '0;
                    if (abort || cnt_inc == len_q) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        mem_add <= '0;
                    end else begin
                        state    <= RD;
                        mem_read <= 1'b1;
                        mem_add  <= src_q + 32'(cnt_inc);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
